// File: rtl/btn_debouncer.sv
`default_nettype none
// btn_debouncer: 4-button synchronizer + per-bit debounce + single-button decode with press/release strobes.
// Optional press_pulse autorepeat is built only when BTN_DEBOUNCER_AUTOREPEAT_EN is defined.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btns,
  output logic [1:0] num,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       multi
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync_q1;
  logic [3:0] sync_q2;
  logic [3:0] stable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 4'b0000;
      sync_q2 <= 4'b0000;
    end else begin
      sync_q1 <= btns;
      sync_q2 <= sync_q1;
    end
  end

  // Each button debounces independently; a bounce back to the stable level restarts its count.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;
    logic             stb;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        stb <= 1'b0;
      end else if (sync_q2[i] == stb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stb <= sync_q2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign stable[i] = stb;
  end

  logic       one_hot;
  logic       many;
  logic [1:0] idx;
  logic       press_evt;
  logic       release_evt;
  logic       rpt_fire;

  always_comb begin
    one_hot = 1'b0;
    many    = 1'b0;
    idx     = num;
    case (stable)
      4'b0000: ;
      4'b0001: begin one_hot = 1'b1; idx = 2'd0; end
      4'b0010: begin one_hot = 1'b1; idx = 2'd1; end
      4'b0100: begin one_hot = 1'b1; idx = 2'd2; end
      4'b1000: begin one_hot = 1'b1; idx = 2'd3; end
      default: many = 1'b1;
    endcase
  end

  // A direct single-to-single switch raises both events in the same cycle.
  assign press_evt   = one_hot && (!pressed || (idx != num));
  assign release_evt = pressed && (!one_hot || (idx != num));

`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
  localparam int               RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_hold;

  assign rpt_hold = pressed && !press_evt && !release_evt;
  assign rpt_fire = rpt_hold && (rpt_cnt == RPT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt <= '0;
    end else if (!rpt_hold || rpt_fire) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYCLES;
  assign rpt_fire          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num           <= 2'd0;
      pressed       <= 1'b0;
      multi         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      num           <= idx;
      pressed       <= one_hot;
      multi         <= many;
      press_pulse   <= press_evt || rpt_fire;
      release_pulse <= release_evt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_debouncer.sv
`default_nettype none
// tb_btn_debouncer: directed self-checking bench for btn_debouncer (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
module tb_btn_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btns = 4'b0000;
  logic [1:0] num;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       multi;

  int tests = 0;
  int fails = 0;

`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  btn_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btns         (btns),
    .num          (num),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .multi        (multi)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input logic [1:0] n, input logic pr, input logic mu,
                                    input logic pp, input logic rp);
    return {n, pr, mu, pp, rp};
  endfunction

  // observed vector layout: {num[1:0], pressed, multi, press_pulse, release_pulse}
  task automatic chk(input string tag, input logic [5:0] exp_v);
    logic [5:0] obs;
    obs = {num, pressed, multi, press_pulse, release_pulse};
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held low with all buttons down
    #1;
    reset = 1'b0;
    btns  = 4'b1111;
    #1;
    chk("reset_async", ex(0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_hold", ex(0, 0, 0, 0, 0));
    end
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("all_held_pre", ex(0, 0, 0, 0, 0));
    end
    tick();
    chk("all_held_multi", ex(0, 0, 1, 0, 0));

    // Release everything
    btns = 4'b0000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("all_rel_pre", ex(0, 0, 1, 0, 0));
    end
    tick();
    chk("all_rel_done", ex(0, 0, 0, 0, 0));

    // Clean press/release of btns[1]
    btns = 4'b0010;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("b1_press_pre", ex(0, 0, 0, 0, 0));
    end
    tick();
    chk("b1_press", ex(1, 1, 0, 1, 0));
    tick();
    chk("b1_press_after", ex(1, 1, 0, 0, 0));
    btns = 4'b0000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("b1_rel_pre", ex(1, 1, 0, 0, 0));
    end
    tick();
    chk("b1_release", ex(1, 0, 0, 0, 1));
    tick();
    chk("b1_release_after", ex(1, 0, 0, 0, 0));

    // btns[2] bouncing every 2 cycles, then held
    for (int k = 0; k < 10; k++) begin
      btns = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int j = 0; j < 2; j++) begin
        tick();
        chk("bounce_quiet", ex(1, 0, 0, 0, 0));
      end
    end
    btns = 4'b0100;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("bounce_settle_pre", ex(1, 0, 0, 0, 0));
    end
    tick();
    chk("bounce_press", ex(2, 1, 0, 1, 0));

    // Direct switch btns[2] -> btns[0]
    btns = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("switch_pre", ex(2, 1, 0, 0, 0));
    end
    tick();
    chk("switch", ex(0, 1, 0, 1, 1));

    // Second button joins: release + multi together
    btns = 4'b0101;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("second_pre", ex(0, 1, 0, 0, 0));
    end
    tick();
    chk("second_multi", ex(0, 0, 1, 0, 1));
    tick();
    chk("second_after", ex(0, 0, 1, 0, 0));

    btns = 4'b0000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("multi_rel_pre", ex(0, 0, 1, 0, 0));
    end
    tick();
    chk("multi_rel", ex(0, 0, 0, 0, 0));

    // btns[3] held, reset mid-hold
    btns = 4'b1000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("b3_pre", ex(0, 0, 0, 0, 0));
    end
    tick();
    chk("b3_press", ex(3, 1, 0, 1, 0));
    for (int e = 8; e <= 10; e++) begin
      tick();
      chk("b3_hold", ex(3, 1, 0, 0, 0));
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midhold_reset_async", ex(0, 0, 0, 0, 0));
    tick();
    chk("midhold_reset_hold", ex(0, 0, 0, 0, 0));
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("b3_rst_pre", ex(0, 0, 0, 0, 0));
    end
    tick();
    chk("b3_rst_press", ex(3, 1, 0, 1, 0));

    // Continued hold: repeat strobes only with autorepeat
    for (int e = 8; e <= 24; e++) begin
      tick();
      chk("b3_repeat", ex(3, 1, 0, AR && (e == 15 || e == 23), 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
